// File: rtl/iq_demod.sv
// iq_demod: mixes offset-binary ADC samples with an NCO cos/sin pair and
// dumps the average of every 2^LOG2_N products as signed I/Q words.
module iq_demod #(
   parameter int LOG2_N = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic [7:0]  adc_in,
   input  logic        sample_valid,
   input  logic [7:0]  phase_inc,
   output logic [15:0] i_out,
   output logic [15:0] q_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overrun
);
   // quarter-wave of round(127*sin(2*pi*k/256)), k = 0..64
   localparam logic [6:0] QLUT [65] = '{
      0, 3, 6, 9, 12, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43, 46,
      49, 51, 54, 57, 60, 63, 65, 68, 71, 73, 76, 78, 81, 83, 85, 88,
      90, 92, 94, 96, 98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
      117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
      127};

   function automatic logic signed [7:0] sin_lut(input logic [7:0] p);
      logic [6:0] m;
      m = p[6] ? 7'(8'd128 - {1'b0, p[6:0]}) : p[6:0];
      return p[7] ? -$signed({1'b0, QLUT[m]}) : $signed({1'b0, QLUT[m]});
   endfunction

   logic [7:0] phase, ph1;
   logic signed [8:0] x1, x2;
   logic signed [7:0] c2, s2;
   logic signed [16:0] pi3, pq3;
   logic signed [23:0] acc_i, acc_q, sum_i, sum_q;
   logic [LOG2_N-1:0] cnt;
   logic v1, v2, v3, dump, load;

   always_comb begin
      sum_i = acc_i + 24'(pi3);
      sum_q = acc_q + 24'(pq3);
      dump = v3 && (cnt == '1);
      load = dump && (!out_valid || out_ready);
   end

   // datapath: qualified only by the valid chain, so no clr needed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1 <= '0;
         ph1 <= '0;
         x2 <= '0;
         c2 <= '0;
         s2 <= '0;
         pi3 <= '0;
         pq3 <= '0;
         i_out <= '0;
         q_out <= '0;
      end else begin
         x1 <= $signed({1'b0, adc_in}) - 9'sd127;
         ph1 <= phase;
         x2 <= x1;
         c2 <= sin_lut(ph1 + 8'd64);
         s2 <= sin_lut(ph1);
         pi3 <= 17'(x2) * 17'(c2);
         pq3 <= 17'(x2) * 17'(s2);
         if (load) begin
            i_out <= 16'(sum_i >>> LOG2_N);
            q_out <= 16'(sum_q >>> LOG2_N);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
         {v1, v2, v3} <= '0;
         acc_i <= '0;
         acc_q <= '0;
         cnt <= '0;
         out_valid <= 1'b0;
         overrun <= 1'b0;
      end else if (clr) begin
         phase <= '0;
         {v1, v2, v3} <= '0;
         acc_i <= '0;
         acc_q <= '0;
         cnt <= '0;
         out_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         v1 <= sample_valid;
         v2 <= v1;
         v3 <= v2;
         if (sample_valid) phase <= phase + phase_inc;
         // cnt wraps to 0 on its own at the N-th sample
         if (v3) begin
            acc_i <= dump ? '0 : sum_i;
            acc_q <= dump ? '0 : sum_q;
            cnt <= cnt + 1'b1;
         end
         if (dump && out_valid && !out_ready) overrun <= 1'b1;
         out_valid <= dump || (out_valid && !out_ready);
      end
   end
endmodule

// File: tb/tb_iq_demod.sv
// tb_iq_demod: scoreboard bench for iq_demod; a real-valued NCO model
// predicts every dump and a monitor compares results on handshake.
module tb_iq_demod;
   logic clk = 0, rst_n = 0, clr = 0, sample_valid = 0, out_ready = 1;
   logic [7:0] adc_in = 0, phase_inc = 0;
   logic [15:0] i_out, q_out;
   logic out_valid, overrun;
   int errors = 0, checks = 0;
   bit mon_en = 1;
   logic [31:0] exp_q[$];
   logic [31:0] e;
   int m_ph = 0, m_cnt = 0;
   longint m_ai = 0, m_aq = 0;

   always #5 clk = ~clk;

   iq_demod #(.LOG2_N(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .adc_in(adc_in),
      .sample_valid(sample_valid), .phase_inc(phase_inc), .i_out(i_out),
      .q_out(q_out), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun));

   function automatic int tsin(int p);
      real r;
      r = 127.0 * $sin(2.0 * 3.141592653589793 * p / 256.0);
      return r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   function automatic void model_reset();
      m_ph = 0;
      m_cnt = 0;
      m_ai = 0;
      m_aq = 0;
      exp_q.delete();
   endfunction

   task automatic send(input logic [7:0] a, input logic [7:0] inc);
      int x;
      x = int'(a) - 127;
      adc_in = a;
      phase_inc = inc;
      sample_valid = 1;
      m_ai += x * tsin((m_ph + 64) % 256);
      m_aq += x * tsin(m_ph);
      m_ph = (m_ph + int'(inc)) % 256;
      m_cnt++;
      if (m_cnt == 16) begin
         exp_q.push_back({16'(m_ai >>> 4), 16'(m_aq >>> 4)});
         m_ai = 0;
         m_aq = 0;
         m_cnt = 0;
      end
      @(negedge clk);
      sample_valid = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr();
      clr = 1;
      @(negedge clk);
      clr = 0;
      model_reset();
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result: unexpected i=%0d q=%0d, required none", $signed(i_out), $signed(q_out));
         end else begin
            e = exp_q.pop_front();
            if ({i_out, q_out} !== e) begin
               errors++;
               $display("FAIL result: got i=%0d q=%0d, required i=%0d q=%0d", $signed(i_out), $signed(q_out), $signed(e[31:16]), $signed(e[15:0]));
            end
         end
      end
   end

   task automatic test_reset();
      idle(2);
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
      if (i_out !== 16'd0) begin errors++; $display("FAIL reset_i: got %0d, required 0", i_out); end
      if (q_out !== 16'd0) begin errors++; $display("FAIL reset_q: got %0d, required 0", q_out); end
      rst_n = 1;
      idle(1);
   endtask

   task automatic test_zero_latency();
      for (int n = 0; n < 16; n++) send(8'd127, 8'd0);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (out_valid !== (c == 3)) begin
            errors++;
            $display("FAIL latency: out_valid=%b after edge k+%0d, required %b", out_valid, c, c == 3);
         end
         if (c < 3) @(negedge clk);
      end
      idle(4);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL zero_drain: %0d results pending, required 0", exp_q.size()); end
   endtask

   task automatic test_dc();
      int n;
      do_clr();
      for (int k = 0; k < 16; k++) send(8'd255, 8'd0);
      n = 0;
      repeat (6) begin
         if (out_valid) n++;
         @(negedge clk);
      end
      checks += 2;
      if (n != 1) begin errors++; $display("FAIL dc_pulse: out_valid high %0d cycles, required 1", n); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL dc_drain: %0d results pending, required 0", exp_q.size()); end
   endtask

   task automatic test_rotate(input int gap);
      logic [7:0] pat [4] = '{8'd254, 8'd127, 8'd0, 8'd127};
      do_clr();
      for (int k = 0; k < 16; k++) begin send(8'd255, 8'd64); idle(gap); end
      idle(5);
      for (int k = 0; k < 16; k++) begin send(pat[k % 4], 8'd64); idle(gap); end
      idle(5);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rotate_drain gap=%0d: %0d results pending, required 0", gap, exp_q.size()); end
   endtask

   task automatic test_overrun();
      do_clr();
      mon_en = 0;
      out_ready = 0;
      for (int k = 0; k < 20; k++) send(8'd255, 8'd0);
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b, required 1", out_valid); end
      if (i_out !== 16'd16256) begin errors++; $display("FAIL ovr_first_i: got %0d, required 16256", i_out); end
      if (q_out !== 16'd0) begin errors++; $display("FAIL ovr_first_q: got %0d, required 0", q_out); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b, required 0", overrun); end
      for (int k = 0; k < 12; k++) send(8'd127, 8'd0);
      idle(4);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid: got %b, required 1", out_valid); end
      if (i_out !== 16'd16256) begin errors++; $display("FAIL ovr_hold_i: got %0d, required 16256", i_out); end
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, required 1", overrun); end
      out_ready = 1;
      @(negedge clk);
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: out_valid=%b, required 0", out_valid); end
      if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", overrun); end
      do_clr();
      checks++;
      if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b, required 0", overrun); end
      mon_en = 1;
   endtask

   task automatic test_async_reset();
      do_clr();
      mon_en = 0;
      out_ready = 0;
      for (int k = 0; k < 16; k++) send(8'd255, 8'd0);
      for (int k = 0; k < 10; k++) send(8'd255, 8'd64);
      #2 rst_n = 0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, required 0", out_valid); end
      if (i_out !== 16'd0) begin errors++; $display("FAIL arst_i: got %0d, required 0", i_out); end
      if (q_out !== 16'd0) begin errors++; $display("FAIL arst_q: got %0d, required 0", q_out); end
      @(negedge clk);
      rst_n = 1;
      model_reset();
      out_ready = 1;
      mon_en = 1;
      for (int k = 0; k < 16; k++) send(8'd255, 8'd0);
      idle(6);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL arst_drain: %0d results pending, required 0", exp_q.size()); end
   endtask

   task automatic test_clr_priority();
      do_clr();
      for (int k = 0; k < 15; k++) send(8'd255, 8'd0);
      adc_in = 8'd255;
      sample_valid = 1;
      clr = 1;
      @(negedge clk);
      clr = 0;
      sample_valid = 0;
      model_reset();
      for (int k = 0; k < 16; k++) send(8'd255, 8'd0);
      idle(6);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL clr_drain: %0d results pending, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_dc();
      test_rotate(0);
      test_overrun();
      test_async_reset();
      test_rotate(2);
      test_clr_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
